axil_reg_slave: RTL
===================

# axil_reg_slave

AXI4-Lite slave register bank that terminates the S00_AXI port of the example IP, directly downstream of the AXI VIP master. It holds four 32-bit read/write user registers and one read-only write counter, and applies byte strobes. It returns SLVERR for undecoded or illegal accesses. The user registers drive the IP core logic through a flat output vector.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width, giving an 8-word decode space.
- NUM_REGS, 4: number of read/write user registers, at word indices 0..NUM_REGS-1.
- ACLK  in  1  single clock. All logic is on the rising edge.
- ARESET  in  1  reset, synchronous, active-high. It is sampled on the ACLK edge.
- S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1; S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1; S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1
- reg_out  out  NUM_REGS*32  user register contents. reg 0 occupies bits [31:0].

## Operation
- Decode uses word index = ADDR[4:2]. ADDR[1:0], AWPROT and ARPROT are ignored.
- Word indices 0..3 are the user registers (RW).
- Word index 4 is WR_COUNT (RO). Writes to it return SLVERR and have no effect.
- Word indices 5..7 are undecoded. Reads return RDATA=0 with SLVERR. Writes return SLVERR and have no effect.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W are captured independently, in either order or in the same cycle.
    - The ready of a captured channel drops to 0 on the following cycle.
    - When both are held, the FSM moves to W_RESP.
  - W_RESP: commit the write, assert BVALID, and hold until BREADY. Then return to W_IDLE with both readies at 1.
- Byte strobes: for each lane b, reg[idx][8b+7:8b] is updated only if WSTRB[b]=1. WSTRB=0 is legal: the response is OKAY and nothing changes.
- WR_COUNT increments by 1 on each OKAY write commit, and only then. It is 32 bits and wraps 0xFFFFFFFF→0.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - On AR handshake: latch RDATA/RRESP, move to R_DATA with ARREADY=0.
  - R_DATA: RVALID=1, held until RREADY. Then return to R_IDLE.
- The write and read paths are fully independent. At most one transaction is outstanding per direction.

## Timing
- Reset values:
  - AWREADY/WREADY/ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, all registers=0, WR_COUNT=0.
  - The readies go to 1 on the first edge on which ARESET is sampled low.
- Write latency: if the last of AW/W handshakes at edge N, then at edge N+1 the register and WR_COUNT update and BVALID rises with BRESP valid.
- Read latency: AR handshake at edge N gives RVALID/RDATA at edge N+1.
- BVALID, BRESP, RVALID, RDATA and RRESP stay stable until their handshake completes. RVALID/BVALID do not depend combinationally on RREADY/BREADY.
- Back-to-back: after a B or R handshake at edge N, the channel readies are 1 from edge N+1. This gives at most one transaction per 2 cycles per direction.
- Simultaneous read and write:
  - RDATA latches register contents as they stood before the same edge, so it sees old data if a write commits on that edge.
  - Reading WR_COUNT likewise returns the pre-increment value.
- Reset mid-operation: ARESET high at any edge clears all state on that edge. Pending BVALID/RVALID drop without a handshake, and captured AW/W are discarded.

## Structure
- Package axil_reg_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Word-index constants REG0..REG3 and WR_COUNT_IDX=4.
  - The enums wr_state_t {W_IDLE,W_RESP} and rd_state_t {R_IDLE,R_DATA}.
- Sub-module axil_reg_bank contains NUM_REGS×32 storage with byte-strobe merge, one write port and one combinational read port. The top level contains both FSMs, decode and WR_COUNT.

## Test plan
- After reset, write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back → each BRESP=OKAY, RDATA matches, RRESP=OKAY, reg_out=0x00000004_00000003_00000002_00000001.
- Write 0xFFFFFFFF to reg0, then write 0x0000AB00 with WSTRB=4'b0010 → read reg0 returns 0xFFFFABFF.
- Present W two cycles before AW (and separately AW before W), with BREADY held low for 3 cycles → a single commit occurs, and BVALID stays high with stable BRESP until BREADY.
- Perform 5 OKAY writes, then write to 0x10 and then to 0x14 → BRESP=SLVERR for both. Read 0x10 returns 5 with OKAY; read 0x18 returns 0 with SLVERR.
- Issue a write to reg1 and a read of reg1 whose commit and RDATA latch fall on the same edge → RDATA is the old value, and the next read returns the new value.
- Assert ARESET for one cycle while BVALID=1 and RVALID=1 → both drop at the next edge, all registers read 0, and WR_COUNT=0.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// Shared constants, state enums and write-port payload for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [IDX_W-1:0] REG0         = 3'd0;
  localparam logic [IDX_W-1:0] REG1         = 3'd1;
  localparam logic [IDX_W-1:0] REG2         = 3'd2;
  localparam logic [IDX_W-1:0] REG3         = 3'd3;
  localparam logic [IDX_W-1:0] WR_COUNT_IDX = 3'd4;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // One committed write as seen by the register bank.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // True when a word index falls inside the user register range.
  function automatic logic is_user_reg(input logic [IDX_W-1:0] idx, input int unsigned nregs);
    return 32'(idx) < nregs;
  endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// User register storage with byte-strobe merge.
// Ports: clk/rst (sync, active-high), we + wr_req write port,
//        rd_idx -> rd_data_c combinational read port, reg_out flat register contents.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  wr_req_t                    wr_req,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data_c,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Merge enabled byte lanes into the addressed register.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr_req.idx == IDX_W'(i)) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_req.strb[b]) begin
              regs_d[i][8*b +: 8] = wr_req.data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port; out-of-range indices read as zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_c = regs_q[i];
      end
    end
  end

  // Flatten storage, reg 0 in the low word.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_out[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave: NUM_REGS RW user registers, a RO write counter at word 4,
// SLVERR for undecoded or read-only targets.
// Ports: ACLK/ARESET (sync, active-high), S_AXI_* AXI4-Lite slave channels,
//        reg_out flat user register contents (reg 0 in bits [31:0]).
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  // Write path state
  wr_state_t         wr_state_q, wr_state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] wr_count_q, wr_count_d;

  // Read path state
  rd_state_t         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_hs_c, w_hs_c, ar_hs_c;
  logic              reg_we_c;
  wr_req_t           wr_req_c;
  logic [IDX_W-1:0]  ar_idx_c;
  logic [DATA_W-1:0] bank_rd_data_c;

  // Address low bits and protection are not decoded.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs_c  = S_AXI_AWVALID && awready_q;
  assign w_hs_c   = S_AXI_WVALID && wready_q;
  assign ar_hs_c  = S_AXI_ARVALID && arready_q;
  assign ar_idx_c = S_AXI_ARADDR[IDX_W+1:2];

  // Write FSM: capture AW/W independently, commit one cycle after both are held.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_count_d = wr_count_q;
    reg_we_c   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[IDX_W+1:2];
        end
        if (w_hs_c) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
          if (is_user_reg(aw_idx_q, NUM_REGS)) begin
            reg_we_c   = 1'b1;
            bresp_d    = RESP_OKAY;
            wr_count_d = wr_count_q + 32'd1;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    // Readies reflect next state so a captured channel closes on the following cycle.
    awready_d = (wr_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (wr_state_d == W_IDLE) && !w_held_d;
  end

  // Read FSM: RDATA samples pre-edge register and counter values.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
          if (is_user_reg(ar_idx_c, NUM_REGS)) begin
            rdata_d = bank_rd_data_c;
            rresp_d = RESP_OKAY;
          end else if (ar_idx_c == WR_COUNT_IDX) begin
            rdata_d = wr_count_q;
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_count_q <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_count_q <= wr_count_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    wr_req_c      = '0;
    wr_req_c.idx  = aw_idx_q;
    wr_req_c.data = wdata_q;
    wr_req_c.strb = wstrb_q;
  end

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk       (ACLK),
    .rst       (ARESET),
    .we        (reg_we_c),
    .wr_req    (wr_req_c),
    .rd_idx    (ar_idx_c),
    .rd_data_c (bank_rd_data_c),
    .reg_out   (reg_out)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule
